// File: rtl/can_sched_pkg.sv
// Shared definitions for the CAN transmit scheduler.
//   CAN_ID_W      : width of a standard CAN identifier
//   sched_state_t : scheduler FSM state encoding
package can_sched_pkg;

  localparam int unsigned CAN_ID_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    COMPLETE
  } sched_state_t;

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority selector: picks the valid slot with the lowest
// identifier; on equal identifiers the lowest slot index wins.
//   valid     : per-slot request flags
//   ids       : packed identifiers, slot i at [CAN_ID_W*i +: CAN_ID_W]
//   any_valid : at least one slot is requesting
//   win_idx   : index of the winning slot (0 when none)
//   win_id    : identifier of the winning slot
module can_prio_select
  import can_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0]          valid,
  input  logic [NUM_SLOTS*CAN_ID_W-1:0] ids,
  output logic                          any_valid,
  output logic [IDX_W-1:0]              win_idx,
  output logic [CAN_ID_W-1:0]           win_id
);

  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    win_id    = '1;
    // Strict less-than keeps the earlier (lower-index) slot on ties.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (valid[i] && (!any_valid || (ids[CAN_ID_W*i +: CAN_ID_W] < win_id))) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_id    = ids[CAN_ID_W*i +: CAN_ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: arbitrates pending slots by identifier, starts the
// TX engine, and tracks per-slot error retries.
//   can_clk, can_rst : clock, asynchronous active-high reset
//   req_valid/req_id : per-slot pending frames and their identifiers
//   bus_idle/tx_ready: qualification for launching a new attempt
//   tx_done/tx_arb_lost/tx_error : completion pulses from the TX engine
//   tx_start/tx_id   : launch pulse and identifier for the TX engine
//   grant            : one-hot slot currently being transmitted
//   slot_done/slot_failed : one-cycle per-slot completion pulses
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned MAX_RETRIES = 8
) (
  input  logic                          can_clk,
  input  logic                          can_rst,
  input  logic [NUM_SLOTS-1:0]          req_valid,
  input  logic [NUM_SLOTS*CAN_ID_W-1:0] req_id,
  input  logic                          bus_idle,
  input  logic                          tx_ready,
  input  logic                          tx_done,
  input  logic                          tx_arb_lost,
  input  logic                          tx_error,
  output logic                          tx_start,
  output logic [CAN_ID_W-1:0]           tx_id,
  output logic [NUM_SLOTS-1:0]          grant,
  output logic [NUM_SLOTS-1:0]          slot_done,
  output logic [NUM_SLOTS-1:0]          slot_failed
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W = $clog2(MAX_RETRIES + 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  winner;
  logic [CNT_W-1:0]  retry_cnt [NUM_SLOTS];

  logic              any_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic [CAN_ID_W-1:0] sel_id;
  logic [CNT_W-1:0]  cnt_inc;

  can_prio_select #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_prio (
    .valid     (req_valid),
    .ids       (req_id),
    .any_valid (any_valid),
    .win_idx   (sel_idx),
    .win_id    (sel_id)
  );

  assign cnt_inc = retry_cnt[winner] + 1'b1;

  always_ff @(posedge can_clk or posedge can_rst) begin
    if (can_rst) begin
      state       <= IDLE;
      winner      <= '0;
      tx_start    <= 1'b0;
      tx_id       <= '0;
      grant       <= '0;
      slot_done   <= '0;
      slot_failed <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        retry_cnt[i] <= '0;
      end
    end else begin
      // Pulse outputs default low; set only on the edge entering their cycle.
      tx_start    <= 1'b0;
      slot_done   <= '0;
      slot_failed <= '0;
      case (state)
        IDLE: begin
          if (any_valid && bus_idle && tx_ready) begin
            state    <= START;
            winner   <= sel_idx;
            grant    <= NUM_SLOTS'(1) << sel_idx;
            tx_id    <= sel_id;
            tx_start <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // Priority: done > error > arbitration loss. grant is one-hot of
          // winner, so it doubles as the per-slot pulse pattern.
          if (tx_done) begin
            slot_done         <= grant;
            retry_cnt[winner] <= '0;
            grant             <= '0;
            state             <= COMPLETE;
          end else if (tx_error) begin
            if (cnt_inc == CNT_W'(MAX_RETRIES)) begin
              slot_failed       <= grant;
              retry_cnt[winner] <= '0;
            end else begin
              retry_cnt[winner] <= cnt_inc;
            end
            grant <= '0;
            state <= COMPLETE;
          end else if (tx_arb_lost) begin
            grant <= '0;
            state <= COMPLETE;
          end
        end
        COMPLETE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of transmit request slots (2..16).
REQ-002 Parameter MAX_RETRIES, default 8, error-terminated attempts per frame before failure (1..255).
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 can_clk  in  1  system clock; all logic on its rising edge.
REQ-005 can_rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  NUM_SLOTS  slot i has a frame pending; held until slot_done[i] or slot_failed[i].
REQ-007 req_id  in  NUM_SLOTS*11  packed 11-bit identifiers; slot i at bits [11*i+10:11*i].
REQ-008 bus_idle  in  1  bus monitor reports bus idle (11 recessive bits seen).
REQ-009 tx_ready  in  1  TX engine idle and able to accept a frame.
REQ-010 tx_done  in  1  one-cycle pulse, frame sent and acknowledged.
REQ-011 tx_arb_lost  in  1  one-cycle pulse, arbitration lost to another node.
REQ-012 tx_error  in  1  one-cycle pulse, bit/ack/form error during frame.
REQ-013 tx_start  out  1  one-cycle pulse starting the TX engine.
REQ-014 tx_id  out  11  identifier of the granted slot, stable from tx_start until completion.
REQ-015 grant  out  NUM_SLOTS  one-hot granted slot, zero when none.
REQ-016 slot_done  out  NUM_SLOTS  one-cycle pulse, slot frame sent.
REQ-017 slot_failed  out  NUM_SLOTS  one-cycle pulse, slot retries exhausted.

Function
REQ-018 FSM states IDLE, START, WAIT, COMPLETE.
REQ-019 IDLE->START when any req_valid, bus_idle and tx_ready are all high in the same cycle; winner, grant and tx_id are registered on that edge.
REQ-020 Winner is the valid slot with the numerically lowest req_id; ties go to the lowest slot index.
REQ-021 tx_start SHALL be high exactly in the START cycle, one cycle after the IDLE qualifying cycle; START->WAIT unconditionally.
REQ-022 WAIT: tx_done->COMPLETE with slot_done[winner] pulsed in COMPLETE; winner retry counter cleared.
REQ-023 WAIT: tx_arb_lost->COMPLETE with no pulse; retry counter unchanged (arbitration loss is not an error).
REQ-024 WAIT: tx_error increments the winner retry counter; if the new value equals MAX_RETRIES, slot_failed[winner] pulses in COMPLETE and the counter clears; otherwise COMPLETE with no pulse.
REQ-025 Simultaneous completion pulses: tx_done wins over tx_error, and tx_error wins over tx_arb_lost.
REQ-026 COMPLETE lasts one cycle, clears grant and returns to IDLE; no slot is selected in COMPLETE, so the requester can drop req_valid.
REQ-027 Deassertion of req_valid[winner] during START/WAIT is ignored; the attempt runs to completion.
REQ-028 Each slot has its own retry counter of width $clog2(MAX_RETRIES+1); counters of non-granted slots never change.
REQ-029 Completion pulses outside WAIT are ignored.
REQ-030 At most one bit of grant, slot_done or slot_failed is high in any cycle.

Reset
REQ-031 On can_rst: state IDLE, tx_start=0, tx_id=0, grant=0, slot_done=0, slot_failed=0, all retry counters 0.
REQ-032 Reset asserted mid-frame aborts the attempt with no slot_done/slot_failed pulse; first grant possible one cycle after the first edge following release.

Structure
REQ-033 Package can_sched_pkg holds CAN_ID_W=11 and the state enum typedef.
REQ-034 Combinational sub-module can_prio_select (lowest-ID, lowest-index winner, plus any-valid flag) is instantiated once.

Verification
REQ-035 Slots 0..3 valid with IDs 0x300,0x120,0x7FF,0x120, bus_idle=tx_ready=1 -> grant=0010, tx_id=0x120, tx_start one cycle after qualification.
REQ-036 Slot 1 granted, tx_done pulse -> slot_done=0010 in next cycle, grant=0 in that cycle, req_valid drop honored with no regrant.
REQ-037 MAX_RETRIES=3, slot 0 valid alone, three tx_error completions -> three tx_start pulses, slot_failed=0001 after the third error, counter back to 0.
REQ-038 Slot 2 (0x050) granted, tx_arb_lost, then slot 0 raises 0x010 -> next grant slot 0 (tx_id 0x010), slot 2 retry counter still 0.
REQ-039 tx_done and tx_error in the same WAIT cycle -> slot_done pulses, no counter increment.
REQ-040 can_rst asserted during WAIT -> all outputs 0 immediately, no completion pulse; after release with req_valid held -> regrant with tx_start.
